key_voice_alloc: RTL and testbench

- Successor to the combinational key-to-note lookup.
- Consumes raw PS/2 set-2 scan bytes and tracks make/break prefixes. Maps keys to MIDI-style note numbers (0..107) and allocates held notes across NUM_VOICES polyphonic voice slots.
- Sits between the PS/2 receiver and the oscillator/voice bank. Each voice slot drives one oscillator.

---
 rtl/synth_key_pkg.sv | 92 +++++++++
 rtl/key_note_map.sv | 31 +++
 rtl/key_voice_alloc.sv | 176 +++++++++++++++++
 tb/tb_key_voice_alloc.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_key_pkg.sv
// Shared constants and types for the keyboard front end: note names,
// PS/2 set-2 prefix bytes, parser states and the key lookup table.
package synth_key_pkg;

    localparam logic [3:0] NOTE_C  = 4'd0;
    localparam logic [3:0] NOTE_CS = 4'd1;
    localparam logic [3:0] NOTE_D  = 4'd2;
    localparam logic [3:0] NOTE_DS = 4'd3;
    localparam logic [3:0] NOTE_E  = 4'd4;
    localparam logic [3:0] NOTE_F  = 4'd5;
    localparam logic [3:0] NOTE_FS = 4'd6;
    localparam logic [3:0] NOTE_G  = 4'd7;
    localparam logic [3:0] NOTE_GS = 4'd8;
    localparam logic [3:0] NOTE_A  = 4'd9;
    localparam logic [3:0] NOTE_AS = 4'd10;
    localparam logic [3:0] NOTE_B  = 4'd11;

    localparam logic [6:0] NOTE_NONE = 7'h7F;
    localparam int         NOTE_MAX  = 107;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_BREAK,
        PS_EXT,
        PS_EXT_BREAK
    } parse_state_t;

    typedef struct packed {
        logic              hit;
        logic [3:0]        semi;
        logic signed [2:0] oct;
    } key_info_t;

    function automatic key_info_t ki(input logic [3:0] s, input int o);
        key_info_t k;
        k.hit  = 1'b1;
        k.semi = s;
        k.oct  = 3'(o);
        return k;
    endfunction

    // Two-row tracker layout; ",L.;/" continue the Z row one octave lower
    function automatic key_info_t key_info(input logic [7:0] code);
        key_info_t k;
        k = '{hit: 1'b0, semi: NOTE_C, oct: 3'sd0};
        case (code)
            8'h15: k = ki(NOTE_C, 0);
            8'h1E: k = ki(NOTE_CS, 0);
            8'h1D: k = ki(NOTE_D, 0);
            8'h26: k = ki(NOTE_DS, 0);
            8'h24: k = ki(NOTE_E, 0);
            8'h2D: k = ki(NOTE_F, 0);
            8'h2E: k = ki(NOTE_FS, 0);
            8'h2C: k = ki(NOTE_G, 0);
            8'h36: k = ki(NOTE_GS, 0);
            8'h35: k = ki(NOTE_A, 0);
            8'h3D: k = ki(NOTE_AS, 0);
            8'h3C: k = ki(NOTE_B, 0);
            8'h43: k = ki(NOTE_C, 1);
            8'h46: k = ki(NOTE_CS, 1);
            8'h44: k = ki(NOTE_D, 1);
            8'h45: k = ki(NOTE_DS, 1);
            8'h4D: k = ki(NOTE_E, 1);
            8'h54: k = ki(NOTE_F, 1);
            8'h55: k = ki(NOTE_FS, 1);
            8'h5B: k = ki(NOTE_G, 1);
            8'h1A: k = ki(NOTE_C, -1);
            8'h1B: k = ki(NOTE_CS, -1);
            8'h22: k = ki(NOTE_D, -1);
            8'h23: k = ki(NOTE_DS, -1);
            8'h21: k = ki(NOTE_E, -1);
            8'h2A: k = ki(NOTE_F, -1);
            8'h34: k = ki(NOTE_FS, -1);
            8'h32: k = ki(NOTE_G, -1);
            8'h33: k = ki(NOTE_GS, -1);
            8'h31: k = ki(NOTE_A, -1);
            8'h3B: k = ki(NOTE_AS, -1);
            8'h3A: k = ki(NOTE_B, -1);
            8'h41: k = ki(NOTE_C, -2);
            8'h4B: k = ki(NOTE_CS, -2);
            8'h49: k = ki(NOTE_D, -2);
            8'h4C: k = ki(NOTE_DS, -2);
            8'h4A: k = ki(NOTE_E, -2);
            default: k = '{hit: 1'b0, semi: NOTE_C, oct: 3'sd0};
        endcase
        return k;
    endfunction

endpackage

// File: rtl/key_note_map.sv
// Combinational scan-code to note lookup with octave arithmetic and
// range qualification (hit=0 for unmapped keys or notes beyond 0..107).
module key_note_map
    import synth_key_pkg::*;
#(
    parameter int NOTE_W   = 7,
    parameter int OCT_BIAS = 2
) (
    input  logic [7:0]        key_code,
    input  logic [2:0]        octave,
    output logic [NOTE_W-1:0] note,
    output logic              hit
);

    localparam logic signed [7:0] BIAS = 8'(OCT_BIAS);
    localparam logic signed [7:0] NMAX = 8'(NOTE_MAX);

    key_info_t         kinfo;
    logic signed [7:0] oct_sum;
    logic signed [7:0] n;

    always_comb begin
        kinfo   = key_info(key_code);
        oct_sum = $signed({5'b0, octave}) + BIAS
                + $signed({{5{kinfo.oct[2]}}, kinfo.oct});
        n       = $signed({4'b0, kinfo.semi}) + oct_sum * 8'sd12;
        hit     = kinfo.hit && (n >= 8'sd0) && (n <= NMAX);
        note    = hit ? NOTE_W'(n[6:0]) : NOTE_W'(NOTE_NONE);
    end

endmodule

// File: rtl/key_voice_alloc.sv
// PS/2 make/break parser and polyphonic voice allocator.
// Build with VOICE_STEAL_EN to steal the oldest voice when all are held.
module key_voice_alloc
    import synth_key_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 7,
    parameter int OCT_BIAS   = 2,
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   scan_code,
    input  logic                         scan_valid,
    input  logic [2:0]                   GLOBAL_octave,
    input  logic                         panic,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic                         evt_valid,
    output logic                         evt_on,
    output logic [VW-1:0]                evt_voice
);

    parse_state_t state_q, state_d;
    logic         do_make, do_break;

    logic [NUM_VOICES-1:0] active_q;
    logic [NOTE_W-1:0]     note_q [NUM_VOICES];
    logic [7:0]            key_q  [NUM_VOICES];

    logic [NOTE_W-1:0]     map_note;
    logic                  map_hit;
    logic [NUM_VOICES-1:0] match;
    logic                  any_free;
    logic [VW-1:0]         free_idx, brk_idx, victim, alloc_idx;
    logic                  alloc_ok;

    key_note_map #(
        .NOTE_W   (NOTE_W),
        .OCT_BIAS (OCT_BIAS)
    ) u_map (
        .key_code (scan_code),
        .octave   (GLOBAL_octave),
        .note     (map_note),
        .hit      (map_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= PS_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        do_make  = 1'b0;
        do_break = 1'b0;
        if (scan_valid) begin
            unique case (state_q)
                PS_IDLE: begin
                    if (scan_code == SC_BREAK)    state_d = PS_BREAK;
                    else if (scan_code == SC_EXT) state_d = PS_EXT;
                    else                          do_make = 1'b1;
                end
                PS_BREAK: begin
                    do_break = 1'b1;
                    state_d  = PS_IDLE;
                end
                PS_EXT: begin
                    state_d = (scan_code == SC_BREAK) ? PS_EXT_BREAK
                                                      : PS_IDLE;
                end
                PS_EXT_BREAK: state_d = PS_IDLE;
                default:      state_d = PS_IDLE;
            endcase
        end
        if (panic) begin
            state_d  = PS_IDLE;
            do_make  = 1'b0;
            do_break = 1'b0;
        end
    end

`ifdef VOICE_STEAL_EN
    localparam logic [VW-1:0] RMAX = {VW{1'b1}};
    logic [VW-1:0] rank_q [NUM_VOICES];
    logic [VW-1:0] best;
    localparam logic CAN_STEAL = 1'b1;

    // Strict compare keeps the lowest index on equal ranks
    always_comb begin
        victim = '0;
        best   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (rank_q[i] > best) begin
                best   = rank_q[i];
                victim = VW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) rank_q[i] <= '0;
        end else if (!panic && alloc_ok) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (i == int'(alloc_idx))
                    rank_q[i] <= '0;
                else if (active_q[i] && rank_q[i] != RMAX)
                    rank_q[i] <= rank_q[i] + 1'b1;
            end
        end
    end
`else
    localparam logic CAN_STEAL = 1'b0;
    assign victim = '0;
`endif

    always_comb begin
        free_idx = '0;
        brk_idx  = '0;
        match    = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            match[i] = active_q[i] && (key_q[i] == scan_code);
            if (!active_q[i]) free_idx = VW'(i);
            if (match[i])     brk_idx  = VW'(i);
        end
        any_free  = ~&active_q;
        alloc_idx = any_free ? free_idx : victim;
        alloc_ok  = do_make && map_hit && !(|match)
                  && (any_free || CAN_STEAL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q  <= '0;
            evt_valid <= 1'b0;
            evt_on    <= 1'b0;
            evt_voice <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= NOTE_W'(NOTE_NONE);
                key_q[i]  <= 8'h00;
            end
        end else begin
            evt_valid <= 1'b0;
            if (panic) begin
                active_q <= '0;
                for (int i = 0; i < NUM_VOICES; i++)
                    note_q[i] <= NOTE_W'(NOTE_NONE);
            end else if (alloc_ok) begin
                active_q[alloc_idx] <= 1'b1;
                note_q[alloc_idx]   <= map_note;
                key_q[alloc_idx]    <= scan_code;
                evt_valid           <= 1'b1;
                evt_on              <= 1'b1;
                evt_voice           <= alloc_idx;
            end else if (do_break && |match) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (match[i]) begin
                        active_q[i] <= 1'b0;
                        note_q[i]   <= NOTE_W'(NOTE_NONE);
                    end
                end
                evt_valid <= 1'b1;
                evt_on    <= 1'b0;
                evt_voice <= brk_idx;
            end
        end
    end

    assign voice_active = active_q;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note
        assign voice_note[g*NOTE_W +: NOTE_W] = note_q[g];
    end

endmodule

// File: tb/tb_key_voice_alloc.sv
// Randomized scoreboard bench for key_voice_alloc against a
// table-driven keyboard model.
module tb_key_voice_alloc;

    localparam int NV = 4;
    localparam int NW = 7;
    localparam int VW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    scan_code;
    logic          scan_valid;
    logic [2:0]    GLOBAL_octave;
    logic          panic;
    logic [NV-1:0] voice_active;
    logic [NV*NW-1:0] voice_note;
    logic          evt_valid;
    logic          evt_on;
    logic [VW-1:0] evt_voice;

    always #5 clk = ~clk;

    key_voice_alloc #(
        .NUM_VOICES (NV),
        .NOTE_W     (NW),
        .OCT_BIAS   (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .scan_code     (scan_code),
        .scan_valid    (scan_valid),
        .GLOBAL_octave (GLOBAL_octave),
        .panic         (panic),
        .voice_active  (voice_active),
        .voice_note    (voice_note),
        .evt_valid     (evt_valid),
        .evt_on        (evt_on),
        .evt_voice     (evt_voice)
    );

    typedef struct packed {
        logic          on;
        logic [VW-1:0] voice;
    } evt_t;

    evt_t exp_q[$];
    evt_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference keyboard: position in a row gives semitone and octave
    logic [7:0] top_row [20] = '{8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24,
        8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C, 8'h43, 8'h46,
        8'h44, 8'h45, 8'h4D, 8'h54, 8'h55, 8'h5B};
    logic [7:0] bot_row [17] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21,
        8'h2A, 8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A, 8'h41, 8'h4B,
        8'h49, 8'h4C, 8'h4A};

    bit         m_act [NV];
    int         m_note[NV];
    logic [7:0] m_key [NV];
    int         m_pre;
    int         m_oct;
`ifdef VOICE_STEAL_EN
    localparam int MAXR = 3;
    int m_age[NV];
`endif

    function automatic int map_note(input logic [7:0] k, input int oct);
        int n;
        n = -1;
        for (int i = 0; i < 20; i++)
            if (top_row[i] == k) n = (i % 12) + 12 * (oct + 2 + i / 12);
        for (int i = 0; i < 17; i++)
            if (bot_row[i] == k)
                n = (i < 12) ? i + 12 * (oct + 1) : (i - 12) + 12 * oct;
        if (n < 0 || n > 107) n = -1;
        return n;
    endfunction

    function automatic void m_clear(input bit keys);
        for (int v = 0; v < NV; v++) begin
            m_act[v]  = 1'b0;
            m_note[v] = 127;
            if (keys) m_key[v] = 8'h00;
`ifdef VOICE_STEAL_EN
            if (keys) m_age[v] = 0;
`endif
        end
        m_pre = 0;
    endfunction

    function automatic void m_make(input logic [7:0] k);
        int n, slot;
        n = map_note(k, m_oct);
        if (n < 0) return;
        for (int v = 0; v < NV; v++)
            if (m_act[v] && m_key[v] == k) return;
        slot = -1;
        for (int v = NV - 1; v >= 0; v--)
            if (!m_act[v]) slot = v;
        if (slot < 0) begin
`ifdef VOICE_STEAL_EN
            slot = 0;
            for (int v = 1; v < NV; v++)
                if (m_age[v] > m_age[slot]) slot = v;
`else
            return;
`endif
        end
`ifdef VOICE_STEAL_EN
        for (int v = 0; v < NV; v++)
            if (v != slot && m_act[v] && m_age[v] < MAXR) m_age[v]++;
        m_age[slot] = 0;
`endif
        m_act[slot]  = 1'b1;
        m_note[slot] = n;
        m_key[slot]  = k;
        exp_q.push_back('{on: 1'b1, voice: VW'(slot)});
    endfunction

    function automatic void m_break(input logic [7:0] k);
        int first;
        first = -1;
        for (int v = 0; v < NV; v++) begin
            if (m_act[v] && m_key[v] == k) begin
                m_act[v]  = 1'b0;
                m_note[v] = 127;
                if (first < 0) first = v;
            end
        end
        if (first >= 0) exp_q.push_back('{on: 1'b0, voice: VW'(first)});
    endfunction

    // m_pre: 0 none, 1 after F0, 2 after E0, 3 after E0 F0
    function automatic void m_byte(input logic [7:0] b);
        case (m_pre)
            1: begin m_pre = 0; m_break(b); end
            2: m_pre = (b == 8'hF0) ? 3 : 0;
            3: m_pre = 0;
            default: begin
                if (b == 8'hF0)      m_pre = 1;
                else if (b == 8'hE0) m_pre = 2;
                else                 m_make(b);
            end
        endcase
    endfunction

    function automatic logic [NV-1:0] exp_act();
        logic [NV-1:0] a;
        for (int v = 0; v < NV; v++) a[v] = m_act[v];
        return a;
    endfunction

    function automatic logic [NV*NW-1:0] exp_notes();
        logic [NV*NW-1:0] r;
        for (int v = 0; v < NV; v++) r[v*NW +: NW] = NW'(m_note[v]);
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic check_state(input string nm);
        check({nm, "_active"}, 64'(voice_active), 64'(exp_act()));
        check({nm, "_notes"}, 64'(voice_note), 64'(exp_notes()));
        check({nm, "_pending_evt"}, 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && evt_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL evt_unexpected: got on=%0d voice=%0d expected none",
                         evt_on, evt_voice);
            end else begin
                mon_e = exp_q.pop_front();
                if ({evt_on, evt_voice} !== mon_e) begin
                    n_err++;
                    $display("FAIL evt: got on=%0d voice=%0d expected on=%0d voice=%0d",
                             evt_on, evt_voice, mon_e.on, mon_e.voice);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_code  = b;
        scan_valid = 1'b1;
        m_byte(b);
        @(negedge clk);
        scan_valid = 1'b0;
        #1;
        check_state("byte");
    endtask

    task automatic do_panic(input bit with_byte, input logic [7:0] b);
        @(negedge clk);
        panic      = 1'b1;
        scan_valid = with_byte;
        scan_code  = b;
        m_clear(1'b0);
        @(negedge clk);
        panic      = 1'b0;
        scan_valid = 1'b0;
        #1;
        check_state("panic");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        m_clear(1'b1);
        #1;
        check("reset_evt_valid", 64'(evt_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_state("reset");
    endtask

    task automatic set_oct(input int o);
        GLOBAL_octave = 3'(o);
        m_oct         = o;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b;
        int r;
        reset      = 1'b1;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        panic      = 1'b0;
        set_oct(3);
        m_clear(1'b1);
        repeat (2) @(negedge clk);
        #1;
        check("rst_active", 64'(voice_active), 64'd0);
        check("rst_notes", 64'(voice_note), 64'({NV{7'h7F}}));
        check("rst_evt_valid", 64'(evt_valid), 64'd0);
        check("rst_evt_on", 64'(evt_on), 64'd0);
        check("rst_evt_voice", 64'(evt_voice), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        send(8'h15);
        check("c4_note", 64'(voice_note[6:0]), 64'd60);
        send(8'hF0); send(8'h15);
        check("c4_off", 64'(voice_note[6:0]), 64'h7F);

        send(8'h15); send(8'h15); send(8'h15);
        check("repeat_active", 64'(voice_active), 64'b0001);
        send(8'hF0); send(8'h15);

        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
        check("fill_notes", 64'(voice_note),
              64'({7'd65, 7'd64, 7'd62, 7'd60}));
        send(8'h2C);
`ifdef VOICE_STEAL_EN
        check("steal_notes", 64'(voice_note),
              64'({7'd65, 7'd64, 7'd62, 7'd67}));
`else
        check("full_notes", 64'(voice_note),
              64'({7'd65, 7'd64, 7'd62, 7'd60}));
`endif
        do_panic(1'b0, 8'h00);

        set_oct(7);
        send(8'h5B);
        check("range_hi", 64'(voice_active), 64'd0);
        set_oct(0);
        send(8'h41);
        check("range_lo", 64'(voice_note[6:0]), 64'd0);
        do_panic(1'b0, 8'h00);

        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        set_oct(3);
        send(8'hF0);
        do_reset();
        send(8'h15);
        check("after_reset_make", 64'(voice_active), 64'b0001);
        do_panic(1'b0, 8'h00);

        send(8'h15);
        set_oct(4);
        send(8'hF0); send(8'h15);
        check("oct_change_off", 64'(voice_active), 64'd0);
        send(8'h15); send(8'h1A); send(8'h43);
        do_panic(1'b1, 8'h2C);
        check("panic_active", 64'(voice_active), 64'd0);

        for (int it = 0; it < 2000; it++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                do_panic(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end else if (r < 8) begin
                set_oct($urandom_range(0, 7));
            end else if (r < 9) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 99);
                if (r < 35)      b = top_row[$urandom_range(0, 19)];
                else if (r < 55) b = bot_row[$urandom_range(0, 16)];
                else if (r < 80) b = 8'hF0;
                else if (r < 88) b = 8'hE0;
                else             b = 8'($urandom_range(0, 255));
                send(b);
            end
        end

        repeat (3) @(negedge clk);
        #1;
        check("final_pending_evt", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
